// File: rtl/gray2raw_upscale.sv
// -----------------------------------------------------------------------------
// gray2raw_upscale
//
// 2x nearest-neighbour upscaler. Takes a half-resolution gray stream
// (IW x IH) and rebuilds a full-resolution frame (W x H). Every input pixel
// becomes a 2x2 block in the output.
//
// Operation alternates between two row states:
//   ROW0 (even output row): each accepted input pixel goes out twice
//        (phase 0, phase 1). It is also written into a one-line buffer.
//   ROW1 (odd output row) : input is stalled. The buffered line is replayed,
//        each pixel twice. Reads from the synchronous buffer are prefetched
//        one pixel ahead so the replay has no gaps.
//
// Ports
//   clk                in   clock
//   rst                in   asynchronous reset, active-high
//   sink_data          in   half-res input pixel      [BITWIDTH-1:0]
//   sink_valid         in   input pixel valid
//   sink_ready         out  block accepts an input pixel
//   source_data        out  full-res output pixel     [BITWIDTH-1:0]
//   source_valid       out  output pixel valid
//   source_ready       in   downstream ready
//   control_in_data    in   {in_w[15:0], in_h[15:0], 4'h0}
//   control_in_valid   in   control word valid
//   control_out_data   out  {2*in_w, 2*in_h, 4'h0} (doubling truncates to 16 bit)
//   control_out_valid  out  control_in_valid, or a one-cycle pulse after reset
//
// Parameters
//   BITWIDTH  pixel width
//   W, H      full-res output size; the input is W/2 x H/2
//
// Build option
//   CONTROL_FROM_PACKET_EN : when defined, the active input width/height come
//   from control packets. A new size stays pending and takes effect at the
//   next frame start. When undefined, the size is fixed at W/2 x H/2.
// -----------------------------------------------------------------------------
module gray2raw_upscale #(
    parameter int BITWIDTH = 8,
    parameter int W        = 1920,
    parameter int H        = 1080
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BITWIDTH-1:0] sink_data,
    input  logic                sink_valid,
    output logic                sink_ready,
    output logic [BITWIDTH-1:0] source_data,
    output logic                source_valid,
    input  logic                source_ready,
    input  logic [35:0]         control_in_data,
    input  logic                control_in_valid,
    output logic [35:0]         control_out_data,
    output logic                control_out_valid
);

    localparam int IW = W / 2;
    localparam int IH = H / 2;
    localparam int AW = (IW > 1) ? $clog2(IW) : 1;

    localparam logic [15:0] IW16 = 16'(IW);
    localparam logic [15:0] IH16 = 16'(IH);

    localparam logic [0:0] ROW0 = 1'b0;
    localparam logic [0:0] ROW1 = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]          state;
    logic [15:0]         x;          // column of the pixel in (or next into) the output register
    logic [15:0]         y;          // input row pair within the frame
    logic [BITWIDTH-1:0] out_data;
    logic                out_phase;  // 0: first copy, 1: second copy of a pixel
    logic                out_valid;

    logic [BITWIDTH-1:0] line_buf [IW];
    logic [BITWIDTH-1:0] rd_data;

    logic                rst_q;      // high until the first clock edge after reset release
    logic                first_q;    // one-cycle pulse following that edge

    // Active input frame size and the size to advertise downstream.
    logic [15:0]         cur_w;
    logic [15:0]         cur_h;
    logic [15:0]         next_w;
    logic [15:0]         next_h;
    logic [15:0]         last_x;
    logic [15:0]         last_y;

    // ------------------------------------------------------------------
    // Handshake and row-position decode
    // ------------------------------------------------------------------
    logic        out_fire;
    logic        in_fire;
    logic        at_last_x;
    logic        accept_ok;
    logic [15:0] wr_addr;

    assign last_x    = cur_w - 16'd1;
    assign last_y    = cur_h - 16'd1;
    assign at_last_x = (x == last_x);
    assign out_fire  = out_valid & source_ready;

    // A new pixel may enter the output register in two cases. The register
    // may be empty. Or its second copy may be leaving this cycle, as long as
    // that pixel is not the last one of the row (no bubble within a row).
    assign accept_ok  = !out_valid | (source_ready & out_phase & !at_last_x);
    assign sink_ready = !rst_q & (state == ROW0) & accept_ok;
    assign in_fire    = sink_valid & sink_ready;

    // If a pixel is still in the register, the incoming one belongs to the next column.
    assign wr_addr = out_valid ? (x + 16'd1) : x;

    // ------------------------------------------------------------------
    // Line buffer read scheduling
    // ------------------------------------------------------------------
    // While the output register holds column x, rd_data holds column x+1.
    // The read of column 0 starts once the last pixel of an even row is in
    // the output register. All writes for that row are finished by then,
    // so a read and a write never coincide.
    logic        rd_en;
    logic [15:0] rd_addr;

    // NOTE: every signal assigned in always_comb gets a default first; otherwise a latch is inferred.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = 16'd0;
        if (state == ROW0) begin
            if (out_valid && at_last_x) begin
                rd_en   = 1'b1;
                // On the ROW0->ROW1 edge, column 0 moves into the output
                // register, so column 1 must be fetched at the same edge.
                rd_addr = (out_fire && out_phase) ? 16'd1 : 16'd0;
            end
        end else begin
            if (out_fire && out_phase && !at_last_x) begin
                rd_en   = 1'b1;
                rd_addr = x + 16'd2;
            end
        end
    end

    // NOTE: the line buffer and its read register have no reset; their contents are overwritten before use.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            line_buf[wr_addr[AW-1:0]] <= sink_data;
        end
        if (rd_en) begin
            rd_data <= line_buf[rd_addr[AW-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Row state machine and output register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ROW0;
            x         <= 16'd0;
            y         <= 16'd0;
            out_data  <= '0;
            out_phase <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ROW0: begin
                    if (in_fire) begin
                        out_data  <= sink_data;
                        out_phase <= 1'b0;
                        out_valid <= 1'b1;
                    end else if (out_fire) begin
                        if (!out_phase) begin
                            out_phase <= 1'b1;
                        end else if (at_last_x) begin
                            // Odd row starts straight from the prefetched column 0.
                            out_data  <= rd_data;
                            out_phase <= 1'b0;
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end

                    if (out_fire && out_phase) begin
                        if (at_last_x) begin
                            x     <= 16'd0;
                            state <= ROW1;
                        end else begin
                            x <= x + 16'd1;
                        end
                    end
                end

                default: begin // ROW1
                    if (out_fire) begin
                        if (!out_phase) begin
                            out_phase <= 1'b1;
                        end else if (!at_last_x) begin
                            out_data  <= rd_data;
                            out_phase <= 1'b0;
                            x         <= x + 16'd1;
                        end else begin
                            out_valid <= 1'b0;
                            x         <= 16'd0;
                            state     <= ROW0;
                            y         <= (y == last_y) ? 16'd0 : y + 16'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign source_data  = out_data;
    assign source_valid = out_valid;

    // ------------------------------------------------------------------
    // Reset-release pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_q   <= 1'b1;
            first_q <= 1'b0;
        end else begin
            rst_q   <= 1'b0;
            first_q <= rst_q;
        end
    end

    // ------------------------------------------------------------------
    // Frame size / control side channel
    // ------------------------------------------------------------------
`ifdef CONTROL_FROM_PACKET_EN
    logic [15:0] pend_w;
    logic [15:0] pend_h;
    logic [15:0] pkt_w;
    logic [15:0] pkt_h;
    logic        pkt_ok;
    logic        frame_start;
    logic        unused_ctrl;

    assign pkt_w = control_in_data[35:20];
    assign pkt_h = control_in_data[19:4];

    // Zero sizes are dropped. So are sizes the line buffer cannot hold.
    assign pkt_ok = control_in_valid && (pkt_w != 16'd0) && (pkt_h != 16'd0)
                    && (pkt_w <= IW16) && (pkt_h <= IH16);

    assign next_w = pkt_ok ? pkt_w : pend_w;
    assign next_h = pkt_ok ? pkt_h : pend_h;

    // Frame boundary: top-left position with nothing in flight.
    assign frame_start = (state == ROW0) && (x == 16'd0) && (y == 16'd0) && !out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_w <= IW16;
            pend_h <= IH16;
            cur_w  <= IW16;
            cur_h  <= IH16;
        end else begin
            pend_w <= next_w;
            pend_h <= next_h;
            if (frame_start) begin
                cur_w <= pend_w;
                cur_h <= pend_h;
            end
        end
    end

    assign unused_ctrl = ^control_in_data[3:0];
`else
    logic unused_ctrl;

    assign cur_w  = IW16;
    assign cur_h  = IH16;
    assign next_w = IW16;
    assign next_h = IH16;

    assign unused_ctrl = ^control_in_data;
`endif

    assign control_out_data  = {next_w[14:0], 1'b0, next_h[14:0], 1'b0, 4'h0};
    assign control_out_valid = control_in_valid | first_q;

endmodule

// File: tb/tb_gray2raw_upscale.sv
// -----------------------------------------------------------------------------
// tb_gray2raw_upscale
//
// Self-checking bench for gray2raw_upscale with W=8, H=4 (input 4x2).
// A frame-level reference model turns each accepted input pixel into its
// expected output beats. Each even-row pixel appears twice. When an input
// row completes, the whole row is appended again, each pixel twice.
// Output beats are popped from that queue and compared.
// -----------------------------------------------------------------------------
module tb_gray2raw_upscale;

    localparam int BW = 8;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int IW = W / 2;
    localparam int IH = H / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] sink_data;
    logic          sink_valid;
    logic          sink_ready;
    logic [BW-1:0] source_data;
    logic          source_valid;
    logic          source_ready;
    logic [35:0]   control_in_data;
    logic          control_in_valid;
    logic [35:0]   control_out_data;
    logic          control_out_valid;

    always #5 clk = ~clk;

    gray2raw_upscale #(.BITWIDTH(BW), .W(W), .H(H)) dut (
        .clk               (clk),
        .rst               (rst),
        .sink_data         (sink_data),
        .sink_valid        (sink_valid),
        .sink_ready        (sink_ready),
        .source_data       (source_data),
        .source_valid      (source_valid),
        .source_ready      (source_ready),
        .control_in_data   (control_in_data),
        .control_in_valid  (control_in_valid),
        .control_out_data  (control_out_data),
        .control_out_valid (control_out_valid)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [BW-1:0] data;
        bit            row_start;  // first beat of an even row (waits on input)
        bit            replay;     // beat of an odd (replayed) row
    } beat_t;

    beat_t         exp_q[$];
    logic [BW-1:0] m_row[$];
    int            m_w, m_h, m_pend_w, m_pend_h, m_pix_frame;

    function automatic void model_reset();
        exp_q.delete();
        m_row.delete();
        m_pend_w    = IW;
        m_pend_h    = IH;
        m_w         = IW;
        m_h         = IH;
        m_pix_frame = 0;
    endfunction

    function automatic void model_push(input logic [BW-1:0] p);
        if (m_pix_frame == 0) begin
            m_w = m_pend_w;
            m_h = m_pend_h;
        end
        exp_q.push_back('{data: p, row_start: (m_row.size() == 0), replay: 1'b0});
        exp_q.push_back('{data: p, row_start: 1'b0, replay: 1'b0});
        m_row.push_back(p);
        m_pix_frame++;
        if (m_row.size() == m_w) begin
            foreach (m_row[i]) begin
                exp_q.push_back('{data: m_row[i], row_start: 1'b0, replay: 1'b1});
                exp_q.push_back('{data: m_row[i], row_start: 1'b0, replay: 1'b1});
            end
            m_row.delete();
            if (m_pix_frame == m_w * m_h) m_pix_frame = 0;
        end
    endfunction

    // ------------------------------------------------------------------
    // Driver / monitor, one call per clock
    // ------------------------------------------------------------------
    int            cyc = 0;
    int            last_beat_cyc = 0;
    int            beats = 0;
    int            pix_left = 0;
    int            next_val = 0;
    bit            rand_data = 1'b0;
    bit            in_f = 1'b0;
    bit            stall_pend = 1'b0;
    logic [BW-1:0] stall_data;
    logic [BW-1:0] first_beat;

    // rmode: 0 ready always, 1 ready toggles, 2 ready random
    // vmode: 0 input offered whenever pixels remain, 1 offered randomly
    task automatic step(input int rmode, input int vmode);
        bit    out_f;
        beat_t b;
        @(negedge clk);
        cyc++;
        if (stall_pend) begin
            check("stall_valid", source_valid, 1'b1);
            check("stall_data", source_data, stall_data);
            stall_pend = 1'b0;
        end

        // Drive inputs for the coming edge; an unaccepted pixel is held.
        if (!(sink_valid && !in_f)) begin
            if (pix_left > 0 && (vmode == 0 || $urandom_range(0, 1) == 1)) begin
                sink_valid = 1'b1;
                sink_data  = rand_data ? BW'($urandom) : BW'(next_val);
                next_val++;
            end else begin
                sink_valid = 1'b0;
                sink_data  = BW'($urandom);
            end
        end
        case (rmode)
            0:       source_ready = 1'b1;
            1:       source_ready = ~source_ready;
            default: source_ready = ($urandom_range(0, 3) != 0);
        endcase
        #1;

        // Observe what the coming edge will transfer.
        in_f  = sink_valid && sink_ready;
        out_f = source_valid && source_ready;
        if (exp_q.size() > 0 && exp_q[0].replay) check("ready_in_row1", sink_ready, 1'b0);
        if (out_f) begin
            check("beat_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                check("beat_data", source_data, b.data);
                if (rmode == 0 && vmode == 0 && !b.row_start)
                    check("beat_gap", 64'(cyc - last_beat_cyc), 64'd1);
            end
            if (beats == 0) first_beat = source_data;
            beats++;
            last_beat_cyc = cyc;
        end
        if (source_valid && !source_ready) begin
            stall_pend = 1'b1;
            stall_data = source_data;
        end
        if (in_f) begin
            model_push(sink_data);
            pix_left--;
        end
    endtask

    task automatic start_run(input int npix, input int first);
        pix_left  = npix;
        rand_data = (first < 0);
        next_val  = first;
        beats     = 0;
    endtask

    task automatic drain(input int rmode, input int vmode, input string tag, input int want_beats);
        for (int i = 0; i < 3000 && (pix_left > 0 || exp_q.size() > 0); i++) step(rmode, vmode);
        check({tag, "_drained"}, 64'(pix_left + exp_q.size()), 64'd0);
        check({tag, "_beats"}, 64'(beats), 64'(want_beats));
    endtask

    // ------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------
    initial begin
        sink_valid       = 1'b0;
        sink_data        = '0;
        source_ready     = 1'b0;
        control_in_valid = 1'b0;
        control_in_data  = '0;
        model_reset();

        // Reset state
        #22;
        check("rst_source_valid", source_valid, 1'b0);
        check("rst_source_data", source_data, '0);
        check("rst_sink_ready", sink_ready, 1'b0);
        check("rst_ctrl_valid", control_out_valid, 1'b0);

        // Reset release: one-cycle control pulse advertising the full-res size
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ctrl_pulse_valid", control_out_valid, 1'b1);
        check("ctrl_pulse_data", control_out_data, {16'd8, 16'd4, 4'h0});
        check("idle_sink_ready", sink_ready, 1'b1);
        @(negedge clk);
        check("ctrl_pulse_end", control_out_valid, 1'b0);

        // 1: input 1..8, always ready -> 32 beats
        start_run(8, 1);
        drain(0, 0, "t1", 32);
        check("t1_first", first_beat, 8'd1);

        // 2: same input, ready toggling
        start_run(8, 1);
        drain(1, 0, "t2", 32);

        // 5: two back-to-back frames, continuous input
        start_run(16, 20);
        drain(0, 0, "t5", 64);

`ifndef CONTROL_FROM_PACKET_EN
        // Control forwarding with the fixed frame size
        @(negedge clk);
        control_in_valid = 1'b1;
        control_in_data  = {4'($urandom), 32'($urandom)};
        #1;
        check("ctrl_fwd_valid", control_out_valid, 1'b1);
        check("ctrl_fwd_data", control_out_data, {16'd8, 16'd4, 4'h0});
        @(negedge clk);
        control_in_valid = 1'b0;
        #1;
        check("ctrl_fwd_idle", control_out_valid, 1'b0);
`endif

        // 4: reset in the middle of the replayed row
        start_run(4, 1);
        for (int i = 0; i < 200 && beats < 11; i++) step(0, 0);
        check("t4_reached_row1", 64'(beats), 64'd11);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_valid", source_valid, 1'b0);
        check("t4_rst_ready", sink_ready, 1'b0);
        model_reset();
        sink_valid = 1'b0;
        in_f       = 1'b0;
        stall_pend = 1'b0;
        pix_left   = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t4_pulse", control_out_valid, 1'b1);
        check("t4_ready_row0", sink_ready, 1'b1);
        start_run(8, 9);
        drain(0, 0, "t4", 32);
        check("t4_first", first_beat, 8'd9);

        // Random traffic: random data, random input and output stalls
        start_run(3 * IW * IH, -1);
        drain(2, 1, "rand", 3 * W * H);

`ifdef CONTROL_FROM_PACKET_EN
        // 6: new size arrives mid-frame and only applies to the next frame
        start_run(8, 40);
        for (int i = 0; i < 200 && pix_left > 5; i++) step(0, 0);
        control_in_valid = 1'b1;
        control_in_data  = {16'd2, 16'd1, 4'h0};
        m_pend_w         = 2;
        m_pend_h         = 1;
        #1;
        check("t6_ctrl_valid", control_out_valid, 1'b1);
        check("t6_ctrl_data", control_out_data, {16'd4, 16'd2, 4'h0});
        @(posedge clk);
        #1 control_in_valid = 1'b0;
        drain(0, 0, "t6_old", 32);
        start_run(2, 60);
        drain(0, 0, "t6_new", 8);
        start_run(2, 70);
        drain(2, 1, "t6_new2", 8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
